assert_handshake_monitor: RTL and testbench
===========================================

ASSERT_HANDSHAKE_MONITOR -- requirements
Module: assert_handshake_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, width of the monitored data bus.
REQ-002 SHALL have parameter MAX_WAIT, default 16, maximum stall cycles allowed (valid high, ready low) before a timeout; legal range 1..255.
REQ-003 SHALL have parameter CNT_W, default 8, width of the violation counter.
REQ-004 SHALL use one clock; reset is synchronous and active-high; ports CLK and RESET.
REQ-005 CLK  input  1  rising-edge clock.
REQ-006 RESET  input  1  synchronous active-high reset.
REQ-007 valid  input  1  monitored producer valid.
REQ-008 ready  input  1  monitored consumer ready.
REQ-009 data  input  WIDTH  monitored payload.
REQ-010 clear  input  1  synchronous clear of the error record.
REQ-011 err  output  1  OR of all sticky error flags.
REQ-012 err_code  output  2  first violation: 0 none, 1 drop, 2 unstable, 3 timeout.
REQ-013 err_count  output  CNT_W  number of violating cycles, saturating.
REQ-014 pending  output  1  high while in state PEND.

Function
REQ-015 SHALL be observation-only: no output feeds the monitored path; the parent instantiates it only under the ASSERT_ON compile guard.
REQ-016 FSM states: IDLE and PEND.
REQ-017 IDLE: valid&ready is a transfer and stays IDLE; valid&!ready goes to PEND, captures data, and sets the wait counter to 1.
REQ-018 PEND, valid low: drop violation; next state IDLE.
REQ-019 PEND, valid high and data != captured: unstable violation in that cycle; evaluation of ready continues the same cycle.
REQ-020 PEND, valid&ready: transfer; next state IDLE.
REQ-021 PEND, valid&!ready: wait counter increments, saturating at MAX_WAIT; the cycle it reaches MAX_WAIT raises one timeout violation; no further timeouts until PEND is left.
REQ-022 Violation detection uses the current-cycle inputs; flags, err_code and err_count update on the next rising edge (1-cycle latency).
REQ-023 err_count SHALL increment by exactly 1 per cycle containing any violation(s), saturating at 2^CNT_W-1.
REQ-024 err_code latches only while 0; simultaneous violations resolve drop > unstable > timeout.
REQ-025 clear zeroes err, err_code and err_count but not the FSM; a violation in the clear cycle is recorded as the first entry after clearing (count 1).
REQ-026 Captured data is not refreshed while in PEND.

Reset
REQ-027 RESET, sampled on CLK, forces state IDLE, pending=0, err=0, err_code=0, err_count=0 and wait counter 0; it overrides clear and all violations.
REQ-028 RESET asserted mid-PEND abandons the pending transfer without a violation.

Structure
REQ-029 Shared package holds the FSM state enum and the err_code constants (ERR_NONE, ERR_DROP, ERR_UNSTABLE, ERR_TIMEOUT).
REQ-030 Saturating counters are one sub-module, sat_counter (parameterised width/limit, inc, clr), used for err_count and the wait counter.

Verification
REQ-031 valid=1, ready=0 for 3 cycles, data held at 0xA5, then ready=1 -> no error; pending high 3 cycles then low.
REQ-032 Stall, then valid drops at cycle 2 -> next cycle err=1, err_code=1, err_count=1, state IDLE.
REQ-033 Stall with data 0x11 changing to 0x22 and valid dropping in the same cycle -> err_code=1, err_count=1 (single increment).
REQ-034 MAX_WAIT=4, 10-cycle stall -> exactly one timeout, err_code=3, err_count=1; CNT_W=2 with 5 violating cycles -> err_count=3.
REQ-035 clear asserted in the same cycle as a drop violation -> after the edge err=1, err_code=1, err_count=1; RESET mid-PEND -> all outputs 0, no error recorded.

Source files
------------

// File: rtl/assert_handshake_monitor_pkg.sv
// Shared types and error-code constants for the valid/ready handshake monitor.
// Error codes are ordered so that a smaller non-zero code wins a tie.
package assert_handshake_monitor_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_DROP     = 2'd1;
  localparam logic [1:0] ERR_UNSTABLE = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  function automatic logic [1:0] first_code(input logic drop, input logic unstable,
                                            input logic timeout);
    if (drop)          return ERR_DROP;
    else if (unstable) return ERR_UNSTABLE;
    else if (timeout)  return ERR_TIMEOUT;
    else               return ERR_NONE;
  endfunction

endpackage

// File: rtl/assert_handshake_monitor_sat_counter.sv
// Saturating up-counter. With clr and inc together the result is 1, so a
// restart and its first count land on the same edge.
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = clr ? '0 : count_q;
    if (inc && (count_d != LIMIT)) begin
      count_d = count_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/assert_handshake_monitor.sv
// Passive valid/ready protocol checker: flags dropped, unstable and stalled
// transfers, keeping the first error code and a saturating violation count.
module assert_handshake_monitor
  import assert_handshake_monitor_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             valid,
  input  logic             ready,
  input  logic [WIDTH-1:0] data,
  input  logic             clear,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_count,
  output logic             pending
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
  localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [2:0]       flags_q, flags_d;
  logic [1:0]       code_q, code_d;
  logic [1:0]       code_base;
  logic [7:0]       wait_cnt;
  logic             wait_inc, wait_clr;
  logic             viol_drop, viol_unst, viol_tmo, viol_any;

  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    wait_inc  = 1'b0;
    wait_clr  = 1'b0;
    viol_drop = 1'b0;
    viol_unst = 1'b0;
    viol_tmo  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wait_clr = 1'b1;
        if (valid && !ready) begin
          state_d  = ST_PEND;
          cap_d    = data;
          wait_inc = 1'b1;
          // With a one-cycle budget the first stall already exhausts it.
          viol_tmo = (MAX_WAIT == 1);
        end
      end
      ST_PEND: begin
        if (!valid) begin
          viol_drop = 1'b1;
          state_d   = ST_IDLE;
          wait_clr  = 1'b1;
        end else begin
          viol_unst = (data != cap_q);
          if (ready) begin
            state_d  = ST_IDLE;
            wait_clr = 1'b1;
          end else begin
            wait_inc = 1'b1;
            viol_tmo = (wait_cnt == WAIT_LAST);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign viol_any = viol_drop | viol_unst | viol_tmo;

  // A clear discards the old record but still admits this cycle's violation.
  always_comb begin
    flags_d   = (clear ? 3'b000 : flags_q) | {viol_tmo, viol_unst, viol_drop};
    code_base = clear ? ERR_NONE : code_q;
    code_d    = (code_base == ERR_NONE) ? first_code(viol_drop, viol_unst, viol_tmo)
                                        : code_base;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cap_q   <= '0;
      flags_q <= 3'b000;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      flags_q <= flags_d;
      code_q  <= code_d;
    end
  end

  sat_counter #(
    .WIDTH(8),
    .LIMIT(WAIT_LIMIT)
  ) u_wait_cnt (
    .clk  (CLK),
    .srst (RESET),
    .inc  (wait_inc),
    .clr  (wait_clr),
    .count(wait_cnt)
  );

  sat_counter #(
    .WIDTH(CNT_W),
    .LIMIT({CNT_W{1'b1}})
  ) u_err_cnt (
    .clk  (CLK),
    .srst (RESET),
    .inc  (viol_any),
    .clr  (clear),
    .count(err_count)
  );

  assign err      = |flags_q;
  assign err_code = code_q;
  assign pending  = (state_q == ST_PEND);

endmodule

// File: tb/tb_assert_handshake_monitor.sv
// Bench for assert_handshake_monitor: directed table, hand sequences and a
// random run compared against a rule-level model, on two parameterisations.
module tb_assert_handshake_monitor;

  logic       CLK;
  logic       RESET;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       clear;

  logic       a_err, b_err;
  logic [1:0] a_code, b_code;
  logic [7:0] a_count;
  logic [1:0] b_count;
  logic       a_pend, b_pend;

  int checks = 0;
  int errors = 0;

  assert_handshake_monitor #(.WIDTH(8), .MAX_WAIT(4), .CNT_W(8)) dut_a (
    .CLK(CLK), .RESET(RESET), .valid(valid), .ready(ready), .data(data), .clear(clear),
    .err(a_err), .err_code(a_code), .err_count(a_count), .pending(a_pend)
  );

  assert_handshake_monitor #(.WIDTH(8), .MAX_WAIT(16), .CNT_W(2)) dut_b (
    .CLK(CLK), .RESET(RESET), .valid(valid), .ready(ready), .data(data), .clear(clear),
    .err(b_err), .err_code(b_code), .err_count(b_count), .pending(b_pend)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Rule-level reference: tracks an outstanding transfer and an error record.
  typedef struct {
    bit         pend;
    logic [7:0] cap;
    int         waits;
    bit         f_drop;
    bit         f_unst;
    bit         f_tmo;
    int         code;
    int         count;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_reset();
    model_t n;
    n.pend = 0; n.cap = '0; n.waits = 0;
    n.f_drop = 0; n.f_unst = 0; n.f_tmo = 0;
    n.code = 0; n.count = 0;
    return n;
  endfunction

  function automatic model_t step(model_t m, bit v, bit r, logic [7:0] d, bit c, bit rst,
                                  int max_wait, int cnt_max);
    model_t n = m;
    bit dr, un, to;
    if (rst) return model_reset();
    dr = m.pend && !v;
    un = m.pend && v && (d != m.cap);
    to = 0;
    if (v && !r) begin
      if (!m.pend) begin
        n.cap   = d;
        n.waits = 1;
        to      = (max_wait == 1);
      end else begin
        n.waits = (m.waits + 1 > max_wait) ? max_wait : m.waits + 1;
        to      = (m.waits < max_wait) && (n.waits == max_wait);
      end
      n.pend = 1;
    end else begin
      n.pend  = 0;
      n.waits = 0;
    end
    if (c) begin
      n.f_drop = 0; n.f_unst = 0; n.f_tmo = 0;
      n.code = 0; n.count = 0;
    end
    if (dr || un || to) begin
      n.count = (n.count < cnt_max) ? n.count + 1 : cnt_max;
      if (n.code == 0) n.code = dr ? 1 : (un ? 2 : 3);
    end
    n.f_drop |= dr;
    n.f_unst |= un;
    n.f_tmo  |= to;
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_models(input string tag);
    chk({tag, " a.err"},     int'(a_err),   int'(ma.f_drop | ma.f_unst | ma.f_tmo));
    chk({tag, " a.code"},    int'(a_code),  ma.code);
    chk({tag, " a.count"},   int'(a_count), ma.count);
    chk({tag, " a.pending"}, int'(a_pend),  int'(ma.pend));
    chk({tag, " b.err"},     int'(b_err),   int'(mb.f_drop | mb.f_unst | mb.f_tmo));
    chk({tag, " b.code"},    int'(b_code),  mb.code);
    chk({tag, " b.count"},   int'(b_count), mb.count);
    chk({tag, " b.pending"}, int'(b_pend),  int'(mb.pend));
  endtask

  task automatic cycle(input bit v, input bit r, input logic [7:0] d, input bit c,
                       input bit rst, input string tag);
    valid = v; ready = r; data = d; clear = c; RESET = rst;
    @(posedge CLK);
    ma = step(ma, v, r, d, c, rst, 4, 255);
    mb = step(mb, v, r, d, c, rst, 16, 3);
    #1;
    $display("%s: v=%0b r=%0b d=%02h clr=%0b rst=%0b -> a: err=%0b code=%0d cnt=%0d pend=%0b | b: err=%0b code=%0d cnt=%0d pend=%0b",
             tag, v, r, d, c, rst, a_err, a_code, a_count, a_pend, b_err, b_code, b_count, b_pend);
    cmp_models(tag);
  endtask

  typedef struct {
    bit         v;
    bit         r;
    logic [7:0] d;
    bit         c;
    bit         rst;
    bit         e_err;
    int         e_code;
    int         e_cnt;
    bit         e_pend;
  } vec_t;

  vec_t tbl[$];

  initial begin
    valid = 0; ready = 0; data = '0; clear = 0; RESET = 1;
    ma = model_reset();
    mb = model_reset();

    //            v  r  d      c  rst err code cnt pend   (expected for dut_a)
    tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 8'hA5, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 8'hA5, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 8'hA5, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 1, 8'hA5, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 8'h3C, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 8'h3C, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 8'h3C, 0, 0, 1, 1, 1, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 8'h11, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 8'h22, 0, 0, 1, 1, 1, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 8'h11, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 1, 8'h22, 0, 0, 1, 2, 1, 0});
    tbl.push_back('{1, 0, 8'h55, 0, 0, 1, 2, 1, 1});
    tbl.push_back('{0, 0, 8'h55, 1, 0, 1, 1, 1, 0});
    tbl.push_back('{1, 0, 8'h66, 0, 0, 1, 1, 1, 1});
    tbl.push_back('{1, 0, 8'h66, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 0, 0, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].c, tbl[i].rst, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d err", i),     int'(a_err),   int'(tbl[i].e_err));
      chk($sformatf("tbl%0d code", i),    int'(a_code),  tbl[i].e_code);
      chk($sformatf("tbl%0d count", i),   int'(a_count), tbl[i].e_cnt);
      chk($sformatf("tbl%0d pending", i), int'(a_pend),  int'(tbl[i].e_pend));
    end

    // Ten-cycle stall: dut_a (budget 4) times out once on the 4th stall cycle.
    cycle(0, 0, 8'h00, 1, 0, "to_clr");
    for (int i = 1; i <= 10; i++) begin
      cycle(1, 0, 8'h77, 0, 0, $sformatf("to%0d", i));
      chk($sformatf("timeout%0d code", i),  int'(a_code),  (i >= 4) ? 3 : 0);
      chk($sformatf("timeout%0d count", i), int'(a_count), (i >= 4) ? 1 : 0);
    end
    chk("stall b.err", int'(b_err), 0);
    cycle(1, 1, 8'h77, 0, 0, "to_done");
    chk("timeout exit count", int'(a_count), 1);
    chk("timeout exit pending", int'(a_pend), 0);

    // Five drops: the 2-bit counter on dut_b must stop at 3.
    cycle(0, 0, 8'h00, 1, 0, "sat_clr");
    for (int k = 1; k <= 5; k++) begin
      cycle(1, 0, 8'h40, 0, 0, $sformatf("sat%0d_stall", k));
      cycle(0, 0, 8'h40, 0, 0, $sformatf("sat%0d_drop", k));
      chk($sformatf("sat%0d b.count", k), int'(b_count), (k < 3) ? k : 3);
      chk($sformatf("sat%0d a.count", k), int'(a_count), k);
    end
    chk("sat b.code", int'(b_code), 1);

    // Random traffic with phases of scarce ready to reach both timeout budgets.
    begin
      logic [7:0] held = 8'h00;
      for (int i = 0; i < 3000; i++) begin
        int  rp;
        bit  v, r, c, rst;
        rp  = ((i / 400) % 2 == 0) ? 40 : 4;
        v   = ($urandom % 5) != 0;
        r   = ($urandom % 100) < rp;
        if (($urandom % 10) == 0) held = 8'($urandom);
        c   = ($urandom % 40) == 0;
        rst = ($urandom % 200) == 0;
        cycle(v, r, held, c, rst, $sformatf("rnd%0d", i));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
